// File: rtl/branch_target_encoder_pkg.sv
// Shared constants and FSM state type for the branch-target encoder and its PC LUT sibling.
package branch_target_encoder_pkg;

   localparam int D = 12;
   localparam int A = 4;
   localparam int N = 2 ** A;

   localparam logic [A-1:0] NO_BRANCH_IDX = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/branch_target_encoder_target_table.sv
// N x D target registers with valid bits; one write port, one combinational read port.
// Writes to the reserved "no branch" index are dropped so entry 0 never becomes valid.
module branch_target_encoder_target_table
   import branch_target_encoder_pkg::*;
(
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         we,
   input  logic [A-1:0] waddr,
   input  logic [D-1:0] wtarget,
   input  logic [A-1:0] raddr,
   output logic [D-1:0] rtarget,
   output logic         rvalid
);

   logic [D-1:0] tgt_q [N];
   logic [N-1:0] vld_q;

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         for (int i = 0; i < N; i++) begin
            tgt_q[i] <= '0;
         end
         vld_q <= '0;
      end else if (we && (waddr != NO_BRANCH_IDX)) begin
         tgt_q[waddr] <= wtarget;
         vld_q[waddr] <= 1'b1;
      end
   end

   assign rtarget = tgt_q[raddr];
   assign rvalid  = vld_q[raddr];

endmodule

// File: rtl/branch_target_encoder.sv
// Maps a 12-bit PC target to its LUT index by a linear scan of indices 1..N-1, one per cycle;
// hit at k responds k cycles after accept, miss after N-1; response held until RspReady, no searches meanwhile.
module branch_target_encoder
   import branch_target_encoder_pkg::*;
(
   input  logic         Clk,
   input  logic         Reset_n,
   input  logic         WrEn,
   input  logic [A-1:0] WrAddr,
   input  logic [D-1:0] WrTarget,
   output logic         WrReady,
   input  logic         SrchValid,
   input  logic [D-1:0] SrchTarget,
   output logic         SrchReady,
   output logic         RspValid,
   output logic         RspHit,
   output logic [A-1:0] RspAddr,
   input  logic         RspReady
);

   state_t       state, state_nxt;
   logic [A-1:0] ptr, ptr_nxt;
   logic [D-1:0] key, key_nxt;
   logic         rsp_valid_nxt;
   logic         rsp_hit_nxt;
   logic [A-1:0] rsp_addr_nxt;
   logic         armed;
   logic [D-1:0] ent_target;
   logic         ent_valid;

   // armed keeps both ready outputs low while reset is held, without an input-to-output path
   assign SrchReady = armed && (state == IDLE);
   assign WrReady   = armed && (state != SCAN);

   branch_target_encoder_target_table u_table (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .we      (WrEn && WrReady),
      .waddr   (WrAddr),
      .wtarget (WrTarget),
      .raddr   (ptr),
      .rtarget (ent_target),
      .rvalid  (ent_valid)
   );

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         state    <= IDLE;
         ptr      <= A'(1);
         key      <= '0;
         RspValid <= 1'b0;
         RspHit   <= 1'b0;
         RspAddr  <= '0;
         armed    <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         key      <= key_nxt;
         RspValid <= rsp_valid_nxt;
         RspHit   <= rsp_hit_nxt;
         RspAddr  <= rsp_addr_nxt;
         armed    <= 1'b1;
      end
   end

   always_comb begin
      state_nxt     = state;
      ptr_nxt       = ptr;
      key_nxt       = key;
      rsp_valid_nxt = RspValid;
      rsp_hit_nxt   = RspHit;
      rsp_addr_nxt  = RspAddr;
      case (state)
         IDLE: begin
            if (SrchValid && SrchReady) begin
               key_nxt   = SrchTarget;
               ptr_nxt   = A'(1);
               state_nxt = SCAN;
            end
         end
         SCAN: begin
            // first match wins, so duplicates resolve to the lowest index
            if (ent_valid && (ent_target == key)) begin
               rsp_valid_nxt = 1'b1;
               rsp_hit_nxt   = 1'b1;
               rsp_addr_nxt  = ptr;
               state_nxt     = RESP;
            end else if (ptr == A'(N - 1)) begin
               rsp_valid_nxt = 1'b1;
               rsp_hit_nxt   = 1'b0;
               rsp_addr_nxt  = NO_BRANCH_IDX;
               state_nxt     = RESP;
            end else begin
               ptr_nxt = ptr + A'(1);
            end
         end
         RESP: begin
            if (RspReady) begin
               rsp_valid_nxt = 1'b0;
               state_nxt     = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_branch_target_encoder.sv
// Directed bench for branch_target_encoder: hand-computed hit/miss, index and latency per scenario.
module tb_branch_target_encoder;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        WrEn;
   logic [3:0]  WrAddr;
   logic [11:0] WrTarget;
   logic        WrReady;
   logic        SrchValid;
   logic [11:0] SrchTarget;
   logic        SrchReady;
   logic        RspValid;
   logic        RspHit;
   logic [3:0]  RspAddr;
   logic        RspReady;

   int nvec = 0;
   int nerr = 0;

   branch_target_encoder dut (
      .Clk        (Clk),
      .Reset_n    (Reset_n),
      .WrEn       (WrEn),
      .WrAddr     (WrAddr),
      .WrTarget   (WrTarget),
      .WrReady    (WrReady),
      .SrchValid  (SrchValid),
      .SrchTarget (SrchTarget),
      .SrchReady  (SrchReady),
      .RspValid   (RspValid),
      .RspHit     (RspHit),
      .RspAddr    (RspAddr),
      .RspReady   (RspReady)
   );

   always #5 Clk = ~Clk;

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic do_write(input logic [3:0] k, input logic [11:0] t);
      WrEn = 1'b1;
      WrAddr = k;
      WrTarget = t;
      tick();
      WrEn = 1'b0;
   endtask

   // Accepts one search and returns cycles from accept edge to RspValid; leaves bench at RspValid.
   task automatic run_search(input logic [11:0] t, output int lat, output logic hit,
                             output logic [3:0] addr);
      int w = 0;
      while (!SrchReady && w < 40) begin
         tick();
         w++;
      end
      nvec++;
      if (SrchReady !== 1'b1) begin
         nerr++;
         $display("FAIL srch_ready_timeout target=%0d SrchReady=%b required 1", t, SrchReady);
      end
      SrchValid = 1'b1;
      SrchTarget = t;
      tick();
      SrchValid = 1'b0;
      lat = 0;
      while (RspValid !== 1'b1 && lat < 40) begin
         tick();
         lat++;
      end
      hit = RspHit;
      addr = RspAddr;
   endtask

   task automatic test_reset();
      int lat;
      logic hit;
      logic [3:0] addr;
      Reset_n = 1'b0;
      SrchValid = 1'b1;
      SrchTarget = 12'd0;
      WrEn = 1'b1;
      WrAddr = 4'd5;
      WrTarget = 12'd0;
      RspReady = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         nvec++;
         if (RspValid !== 1'b0 || SrchReady !== 1'b0) begin
            nerr++;
            $display("FAIL reset_hold RspValid=%b SrchReady=%b required 0 0", RspValid, SrchReady);
         end
      end
      Reset_n = 1'b1;
      SrchValid = 1'b0;
      WrEn = 1'b0;
      tick();
      nvec++;
      if ({SrchReady, WrReady, RspValid, RspHit, RspAddr} !== 8'b1100_0000) begin
         nerr++;
         $display("FAIL reset_release SrchReady=%b WrReady=%b RspValid=%b RspHit=%b RspAddr=%0d required 1 1 0 0 0",
                  SrchReady, WrReady, RspValid, RspHit, RspAddr);
      end
      run_search(12'd0, lat, hit, addr);
      nvec++;
      if (lat != 15 || hit !== 1'b0 || addr !== 4'd0) begin
         nerr++;
         $display("FAIL reset_search0 lat=%0d hit=%b addr=%0d required 15 0 0", lat, hit, addr);
      end
      tick();
   endtask

   task automatic test_load_hit();
      int lat;
      logic hit;
      logic [3:0] addr;
      do_write(4'd1, 12'd45);
      do_write(4'd2, 12'd69);
      do_write(4'd3, 12'd80);
      do_write(4'd4, 12'd91);
      run_search(12'd80, lat, hit, addr);
      nvec++;
      if (lat != 3 || hit !== 1'b1 || addr !== 4'd3) begin
         nerr++;
         $display("FAIL hit_80 lat=%0d hit=%b addr=%0d required 3 1 3", lat, hit, addr);
      end
      tick();
      run_search(12'd45, lat, hit, addr);
      nvec++;
      if (lat != 1 || hit !== 1'b1 || addr !== 4'd1) begin
         nerr++;
         $display("FAIL hit_45 lat=%0d hit=%b addr=%0d required 1 1 1", lat, hit, addr);
      end
      tick();
   endtask

   task automatic test_miss_latency();
      int lat = 0;
      int bad_rdy = 0;
      logic hit;
      logic [3:0] addr;
      SrchValid = 1'b1;
      SrchTarget = 12'd100;
      tick();
      SrchValid = 1'b0;
      // try to plant 100 at index 3 throughout the scan
      while (RspValid !== 1'b1 && lat < 40) begin
         if (WrReady !== 1'b0) bad_rdy++;
         WrEn = 1'b1;
         WrAddr = 4'd3;
         WrTarget = 12'd100;
         tick();
         lat++;
      end
      WrEn = 1'b0;
      nvec++;
      if (bad_rdy != 0) begin
         nerr++;
         $display("FAIL wrready_in_scan cycles_with_WrReady=%0d required 0", bad_rdy);
      end
      nvec++;
      if (lat != 15 || RspHit !== 1'b0 || RspAddr !== 4'd0) begin
         nerr++;
         $display("FAIL miss_100 lat=%0d hit=%b addr=%0d required 15 0 0", lat, RspHit, RspAddr);
      end
      tick();
      run_search(12'd80, lat, hit, addr);
      nvec++;
      if (lat != 3 || hit !== 1'b1 || addr !== 4'd3) begin
         nerr++;
         $display("FAIL table_unchanged_80 lat=%0d hit=%b addr=%0d required 3 1 3", lat, hit, addr);
      end
      tick();
   endtask

   task automatic test_dup_reserved();
      int lat;
      logic hit;
      logic [3:0] addr;
      do_write(4'd0, 12'd69);
      do_write(4'd7, 12'd69);
      run_search(12'd69, lat, hit, addr);
      nvec++;
      if (lat != 2 || hit !== 1'b1 || addr !== 4'd2) begin
         nerr++;
         $display("FAIL dup_69_low lat=%0d hit=%b addr=%0d required 2 1 2", lat, hit, addr);
      end
      tick();
      do_write(4'd2, 12'd50);
      run_search(12'd69, lat, hit, addr);
      nvec++;
      if (lat != 7 || hit !== 1'b1 || addr !== 4'd7) begin
         nerr++;
         $display("FAIL dup_69_after_overwrite lat=%0d hit=%b addr=%0d required 7 1 7", lat, hit, addr);
      end
      tick();
      run_search(12'd50, lat, hit, addr);
      nvec++;
      if (lat != 2 || hit !== 1'b1 || addr !== 4'd2) begin
         nerr++;
         $display("FAIL overwrite_50 lat=%0d hit=%b addr=%0d required 2 1 2", lat, hit, addr);
      end
      tick();
   endtask

   task automatic test_backpressure();
      int lat;
      logic hit;
      logic [3:0] addr;
      RspReady = 1'b0;
      run_search(12'd91, lat, hit, addr);
      nvec++;
      if (lat != 4 || hit !== 1'b1 || addr !== 4'd4) begin
         nerr++;
         $display("FAIL bp_hit_91 lat=%0d hit=%b addr=%0d required 4 1 4", lat, hit, addr);
      end
      SrchValid = 1'b1;
      SrchTarget = 12'd45;
      for (int i = 0; i < 5; i++) begin
         nvec++;
         if (RspValid !== 1'b1 || RspHit !== 1'b1 || RspAddr !== 4'd4 || SrchReady !== 1'b0) begin
            nerr++;
            $display("FAIL bp_hold cyc=%0d RspValid=%b RspHit=%b RspAddr=%0d SrchReady=%b required 1 1 4 0",
                     i, RspValid, RspHit, RspAddr, SrchReady);
         end
         tick();
      end
      RspReady = 1'b1;
      tick();
      nvec++;
      if (RspValid !== 1'b0 || SrchReady !== 1'b1) begin
         nerr++;
         $display("FAIL bp_release RspValid=%b SrchReady=%b required 0 1", RspValid, SrchReady);
      end
      tick();
      SrchValid = 1'b0;
      nvec++;
      if (SrchReady !== 1'b0) begin
         nerr++;
         $display("FAIL bp_next_accept SrchReady=%b required 0", SrchReady);
      end
      tick();
      nvec++;
      if (RspValid !== 1'b1 || RspHit !== 1'b1 || RspAddr !== 4'd1) begin
         nerr++;
         $display("FAIL bp_next_rsp RspValid=%b RspHit=%b RspAddr=%0d required 1 1 1",
                  RspValid, RspHit, RspAddr);
      end
      tick();
   endtask

   task automatic test_reset_midscan();
      int lat;
      int spurious = 0;
      logic hit;
      logic [3:0] addr;
      SrchValid = 1'b1;
      SrchTarget = 12'd100;
      tick();
      SrchValid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      Reset_n = 1'b0;
      tick();
      Reset_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (RspValid !== 1'b0) spurious++;
         tick();
      end
      nvec++;
      if (spurious != 0) begin
         nerr++;
         $display("FAIL midscan_no_rsp cycles_with_RspValid=%0d required 0", spurious);
      end
      run_search(12'd80, lat, hit, addr);
      nvec++;
      if (lat != 15 || hit !== 1'b0 || addr !== 4'd0) begin
         nerr++;
         $display("FAIL cleared_80 lat=%0d hit=%b addr=%0d required 15 0 0", lat, hit, addr);
      end
      tick();
      run_search(12'd69, lat, hit, addr);
      nvec++;
      if (lat != 15 || hit !== 1'b0 || addr !== 4'd0) begin
         nerr++;
         $display("FAIL cleared_69 lat=%0d hit=%b addr=%0d required 15 0 0", lat, hit, addr);
      end
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_load_hit();
      test_miss_latency();
      test_dup_reserved();
      test_backpressure();
      test_reset_midscan();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/branch_target_encoder.md
Name: branch_target_encoder

Overview:
Reverse companion to the branch-target LUT: maps an absolute 12-bit PC target back to its 4-bit LUT index.
- Holds a loadable 16-entry target table, written by the program loader/assembler side.
- Accepts search requests over a valid/ready handshake and scans the table one entry per cycle.
- Returns hit/miss plus index; sits beside fetch, feeding the loader's branch-encoding and debug paths.

Parameters:
D, 12, PC/target width in bits
A, 4, index width; table depth N = 2**A

Ports:
Clk  input  1  clock, all state updates on rising edge
Reset_n  input  1  synchronous active-low reset, sampled on rising edge of Clk
WrEn  input  1  table write request
WrAddr  input  A  table index to write
WrTarget  input  D  target PC to store
WrReady  output  1  write accepted this cycle when WrEn & WrReady
SrchValid  input  1  search request valid
SrchTarget  input  D  PC to look up
SrchReady  output  1  search accepted when SrchValid & SrchReady
RspValid  output  1  response valid
RspHit  output  1  1 = match found
RspAddr  output  A  matching index (0 on miss)
RspReady  input  1  consumer accepts response

Behaviour:
- Reset (Reset_n=0 at an edge): all entries target=0, valid=0; state IDLE; RspValid=0, RspHit=0, RspAddr=0; internal pointer=1; latched key=0. Reset overrides every other input, including mid-scan; any in-flight search is dropped with no response.
- Index 0 is reserved ("no branch"): writes to WrAddr=0 are accepted but discarded; entry 0 is never compared.
- Write: WrReady=1 in IDLE and RESP, 0 in SCAN. On WrEn&WrReady at WrAddr k≠0: entry k ← WrTarget, valid[k] ← 1, visible to a search accepted the next cycle or later. Rewriting an index overwrites it.
- FSM states: IDLE, SCAN, RESP.
  - IDLE: SrchReady=1. On SrchValid: latch SrchTarget as key, pointer ← 1, go to SCAN. A simultaneous write in the accept cycle is applied and is seen by the scan.
  - SCAN: SrchReady=0. Each cycle compare entry[pointer] against the key; an entry matches only if valid and equal in all D bits.
    - Match: RspHit ← 1, RspAddr ← pointer, go to RESP.
    - No match at pointer=N-1: RspHit ← 0, RspAddr ← 0, go to RESP.
    - Otherwise pointer ← pointer+1. Pointer never wraps; the scan covers indices 1..N-1 exactly once.
  - RESP: RspValid=1, RspHit/RspAddr stable. Hold until RspReady=1 at an edge, then RspValid ← 0 and go to IDLE. SrchReady=0 in RESP; back-to-back requests cost one idle cycle.
- Latency: accept at edge E0. A hit at index k makes RspValid visible after edge E0+k. A miss makes it visible after edge E0+(N-1) (15 cycles at default).
- Duplicate targets: the lowest index wins.
- Outputs are registered: RspValid, RspHit, RspAddr. SrchReady and WrReady are decoded from state only (no input-to-output combinational path).

Decomposition:
- Shared package holds:
  - typedef for the state enum {IDLE, SCAN, RESP};
  - D, A and N constants shared with the PC LUT;
  - localparam for reserved index NO_BRANCH_IDX=0.
- One natural sub-module, target_table: N×D register array plus valid bits; one write port, one indexed read port. Its reset clears all entries.

Test Plan:
- Reset: Reset_n=0 for 2 cycles with SrchValid=1, WrEn=1 → RspValid=0, SrchReady=0 during reset; SrchReady=1 and WrReady=1 after release; an immediate search for 0 → miss, RspAddr=0 (entry 0 never matched, invalid entries never matched).
- Load and hit: write 1→45, 2→69, 3→80, 4→91; search 80 → RspValid 3 cycles after accept, RspHit=1, RspAddr=3; search 45 → RspAddr=1 after 1 cycle.
- Miss and latency: same table, search 100 → RspValid exactly 15 cycles after accept, RspHit=0, RspAddr=0; WrEn held high during the scan → WrReady=0, table unchanged afterwards.
- Duplicates and reserved slot: write 0→69 and 7→69 over the load above; search 69 → RspAddr=2; then overwrite 2→50; search 69 → RspAddr=7.
- Backpressure: hit on 91 with RspReady=0 for 5 cycles → RspValid, RspHit=1, RspAddr=4 held stable and SrchReady=0; RspReady=1 → IDLE next cycle, new request accepted one cycle later.
- Reset mid-scan: search 100, assert Reset_n=0 at scan cycle 6 → no response; table cleared; a following search for 80 → miss.
